// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: owns the single VRAM write port and arbitrates it
// between buffered CPU writes (drained only while it is safe for scanout)
// and the fill engine, which gets exclusive use of the port on request.
// Optional build macro: VRAM_WRITE_COALESCE_EN. When defined, a CPU write
// to the same address as the newest queued entry overwrites that entry's data.
module vram_write_scheduler #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 16,
  parameter int VBLANK_ONLY = 1
) (
  input  logic                       clk_12_5875,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          cpu_address,
  input  logic [7:0]                 cpu_data,
  input  logic                       cpu_write_enable,
  output logic                       cpu_full,
  input  logic                       fill_req,
  output logic                       fill_grant,
  input  logic [ADDR_W-1:0]          fill_address,
  input  logic [7:0]                 fill_data,
  input  logic                       fill_write_enable,
  input  logic                       in_vblank,
  output logic [ADDR_W-1:0]          vram_address,
  output logic [7:0]                 vram_data,
  output logic                       vram_write_enable,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [7:0]        mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic              drain_ok;
  logic              pop;
  logic              push;
  logic              drop;
  logic              coalesce;
  logic              fill_wr;
  logic              overflow_q;

  assign drain_ok = in_vblank | (VBLANK_ONLY == 0);
  // Fill preempts the drain immediately, so no entry is popped while fill_req is high.
  assign pop      = (state == DRAIN) && drain_ok && !fill_req && (count != '0);
  assign fill_wr  = (state == FILL) && fill_write_enable;

`ifdef VRAM_WRITE_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;
  assign last_ptr = wr_ptr - PTR_ONE;
  // Merge into the newest entry unless it is empty or leaving the FIFO this cycle.
  assign coalesce = cpu_write_enable && (count != '0) &&
                    (mem_addr[last_ptr] == cpu_address) &&
                    !(pop && (rd_ptr == last_ptr));
`else
  assign coalesce = 1'b0;
`endif

  assign push = cpu_write_enable && !coalesce && (count != CNT_FULL);
  assign drop = cpu_write_enable && !coalesce && (count == CNT_FULL);

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // FIFO pointers and occupancy; reset discards all queued entries.
  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_12_5875) begin
    if (push) begin
      mem_addr[wr_ptr] <= cpu_address;
      mem_data[wr_ptr] <= cpu_data;
    end
`ifdef VRAM_WRITE_COALESCE_EN
    if (coalesce) begin
      mem_data[last_ptr] <= cpu_data;
    end
`endif
  end

  // Sticky overflow: a dropped write wins over a same-cycle clear.
  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // Port ownership state register.
  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: fill has priority; drain stops on empty, end of vblank or fill request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (fill_req) begin
          state_next = FILL;
        end else if ((count != '0) && drain_ok) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fill_req || !drain_ok || (count_next == '0)) begin
          state_next = IDLE;
        end
      end
      FILL: begin
        if (!fill_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered VRAM write port; strobes only for a popped entry or a granted fill write.
  always_ff @(posedge clk_12_5875 or negedge rst_n) begin
    if (!rst_n) begin
      vram_address      <= '0;
      vram_data         <= '0;
      vram_write_enable <= 1'b0;
    end else begin
      vram_write_enable <= pop | fill_wr;
      if (pop) begin
        vram_address <= mem_addr[rd_ptr];
        vram_data    <= mem_data[rd_ptr];
      end else if (fill_wr) begin
        vram_address <= fill_address;
        vram_data    <= fill_data;
      end
    end
  end

  assign fill_grant = (state == FILL);
  assign cpu_full   = (count == CNT_FULL);
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Self-checking bench for vram_write_scheduler: a scoreboard holds the
// expected VRAM writes (CPU queue and fill path separately) and a monitor
// compares every strobed write against it.
module tb_vram_write_scheduler;

  localparam int DEPTH = 16;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_12_5875 = 1'b0;
  logic        rst_n;
  logic [11:0] cpu_address;
  logic [7:0]  cpu_data;
  logic        cpu_write_enable;
  logic        cpu_full;
  logic        fill_req;
  logic        fill_grant;
  logic [11:0] fill_address;
  logic [7:0]  fill_data;
  logic        fill_write_enable;
  logic        in_vblank;
  logic [11:0] vram_address;
  logic [7:0]  vram_data;
  logic        vram_write_enable;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic        clr_overflow;

  int  checks      = 0;
  int  errors      = 0;
  int  write_count = 0;
  int  model_count = 0;
  bit  fill_phase  = 0;
  wr_t sb_fifo[$];
  wr_t sb_fill[$];
  wr_t mon_e;

  vram_write_scheduler #(.ADDR_W(12), .DEPTH(DEPTH), .VBLANK_ONLY(1)) dut (
    .clk_12_5875      (clk_12_5875),
    .rst_n            (rst_n),
    .cpu_address      (cpu_address),
    .cpu_data         (cpu_data),
    .cpu_write_enable (cpu_write_enable),
    .cpu_full         (cpu_full),
    .fill_req         (fill_req),
    .fill_grant       (fill_grant),
    .fill_address     (fill_address),
    .fill_data        (fill_data),
    .fill_write_enable(fill_write_enable),
    .in_vblank        (in_vblank),
    .vram_address     (vram_address),
    .vram_data        (vram_data),
    .vram_write_enable(vram_write_enable),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .clr_overflow     (clr_overflow)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  // Monitor: every VRAM write must match the head of the relevant expected queue.
  always @(posedge clk_12_5875) begin
    #1;
    if (rst_n === 1'b1 && vram_write_enable === 1'b1) begin
      write_count++;
      checks++;
      if (fill_phase) begin
        if (sb_fill.size() == 0) begin
          errors++;
          $display("[TB] FAIL fill_write unexpected addr=%h data=%h", vram_address, vram_data);
        end else begin
          mon_e = sb_fill.pop_front();
          if (vram_address !== mon_e.a || vram_data !== mon_e.d) begin
            errors++;
            $display("[TB] FAIL fill_write got %h/%h expected %h/%h",
                     vram_address, vram_data, mon_e.a, mon_e.d);
          end
        end
      end else begin
        if (sb_fifo.size() == 0) begin
          errors++;
          $display("[TB] FAIL cpu_write unexpected addr=%h data=%h", vram_address, vram_data);
        end else begin
          mon_e = sb_fifo.pop_front();
          model_count--;
          if (vram_address !== mon_e.a || vram_data !== mon_e.d) begin
            errors++;
            $display("[TB] FAIL cpu_write got %h/%h expected %h/%h",
                     vram_address, vram_data, mon_e.a, mon_e.d);
          end
        end
      end
    end
  end

  // One CPU write cycle, starting and ending on a falling edge; updates the model.
  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input logic clr);
    bit  merged;
    wr_t e;
    merged = 0;
    cpu_address      = a;
    cpu_data         = d;
    cpu_write_enable = 1'b1;
    clr_overflow     = clr;
`ifdef VRAM_WRITE_COALESCE_EN
    if (model_count > 0 && sb_fifo.size() > 0) begin
      e = sb_fifo.pop_back();
      if (e.a == a) begin
        e.d    = d;
        merged = 1;
      end
      sb_fifo.push_back(e);
    end
`endif
    if (!merged && model_count < DEPTH) begin
      e.a = a;
      e.d = d;
      sb_fifo.push_back(e);
      model_count++;
    end
    @(negedge clk_12_5875);
    cpu_write_enable = 1'b0;
    clr_overflow     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_12_5875);
    checks++; if (vram_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_vram_we got %b expected 0", vram_write_enable); end
    checks++; if (vram_address !== 12'h000) begin errors++; $display("[TB] FAIL reset_vram_addr got %h expected 000", vram_address); end
    checks++; if (vram_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_vram_data got %h expected 00", vram_data); end
    checks++; if (fill_grant !== 1'b0) begin errors++; $display("[TB] FAIL reset_fill_grant got %b expected 0", fill_grant); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_fifo_count got %0d expected 0", fifo_count); end
    checks++; if (cpu_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got full=%b ovf=%b expected 0 0", cpu_full, overflow); end
    rst_n = 1'b1;
    @(negedge clk_12_5875);
  endtask

  task automatic test_vblank_drain();
    int wc0;
    in_vblank = 1'b0;
    for (int i = 0; i < 8; i++) cpu_write(12'(i), 8'h0F, 1'b0);
    wc0 = write_count;
    repeat (3) @(negedge clk_12_5875);
    checks++; if (fifo_count !== 5'd8) begin errors++; $display("[TB] FAIL hold_count got %0d expected 8", fifo_count); end
    checks++; if (write_count != wc0) begin errors++; $display("[TB] FAIL hold_no_write got %0d writes expected 0", write_count - wc0); end
    in_vblank = 1'b1;
    @(posedge clk_12_5875); #2;
    checks++; if (vram_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL drain_early got %b expected 0", vram_write_enable); end
    @(posedge clk_12_5875); #2;
    checks++; if (vram_write_enable !== 1'b1) begin errors++; $display("[TB] FAIL drain_latency got %b expected 1", vram_write_enable); end
    repeat (7) @(posedge clk_12_5875);
    #2;
    checks++; if (write_count != wc0 + 8) begin errors++; $display("[TB] FAIL drain_burst got %0d writes expected 8", write_count - wc0); end
    @(posedge clk_12_5875); #2;
    checks++; if (vram_write_enable !== 1'b0) begin errors++; $display("[TB] FAIL drain_end_we got %b expected 0", vram_write_enable); end
    @(negedge clk_12_5875);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL drain_end_count got %0d expected 0", fifo_count); end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
  endtask

  task automatic test_overflow();
    bit done;
    in_vblank = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) cpu_write(12'h100 + 12'(i), 8'(i), 1'b0);
    checks++; if (cpu_full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %b expected 1", cpu_full); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got %b expected 1", overflow); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count got %0d expected 16", fifo_count); end
    cpu_write(12'h120, 8'h55, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_wins got %b expected 1", overflow); end
    clr_overflow = 1'b1;
    @(negedge clk_12_5875);
    clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got %b expected 0", overflow); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("[TB] FAIL ovf_count_kept got %0d expected 16", fifo_count); end
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk_12_5875);
      if (fifo_count === 5'd0) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL ovf_drain_timeout count=%0d expected 0", fifo_count); end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
    checks++; if (cpu_full !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_clear got %b expected 0", cpu_full); end
  endtask

  task automatic test_partial_drain();
    int  wc0;
    bit  done;
    in_vblank = 1'b0;
    for (int i = 0; i < 6; i++) cpu_write(12'h200 + 12'(i), 8'hA0 + 8'(i), 1'b0);
    wc0 = write_count;
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (write_count == wc0 + 3) done = 1;
    end
    in_vblank = 1'b0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL partial_timeout got %0d writes expected 3", write_count - wc0); end
    repeat (5) @(negedge clk_12_5875);
    checks++; if (write_count != wc0 + 3) begin errors++; $display("[TB] FAIL partial_writes got %0d expected 3", write_count - wc0); end
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("[TB] FAIL partial_count got %0d expected 3", fifo_count); end
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (write_count == wc0 + 6 && fifo_count === 5'd0) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL partial_resume got %0d writes expected 6", write_count - wc0); end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
  endtask

  task automatic test_fill_preempt();
    int  wc0;
    bit  done;
    wr_t e;
    in_vblank = 1'b0;
    for (int i = 0; i < 6; i++) cpu_write(12'h300 + 12'(i), 8'h30 + 8'(i), 1'b0);
    wc0 = write_count;
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (write_count == wc0 + 2) done = 1;
    end
    fill_req = 1'b1;
    checks++; if (!done) begin errors++; $display("[TB] FAIL fill_pre_drain got %0d writes expected 2", write_count - wc0); end
    done = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      @(negedge clk_12_5875);
      if (fill_grant === 1'b1) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL fill_grant_timeout got %b expected 1", fill_grant); end
    checks++; if (write_count != wc0 + 2) begin errors++; $display("[TB] FAIL fill_drain_stop got %0d writes expected 2", write_count - wc0); end
    checks++; if (fifo_count !== 5'd4) begin errors++; $display("[TB] FAIL fill_fifo_held got %0d expected 4", fifo_count); end
    fill_phase        = 1;
    fill_address      = 12'h800;
    fill_data         = 8'h0F;
    fill_write_enable = 1'b1;
    e.a = 12'h800; e.d = 8'h0F; sb_fill.push_back(e);
    @(posedge clk_12_5875); #2;
    checks++; if (vram_write_enable !== 1'b1 || vram_address !== 12'h800 || vram_data !== 8'h0F) begin
      errors++; $display("[TB] FAIL fill_latency got we=%b %h/%h expected 1 800/0f", vram_write_enable, vram_address, vram_data);
    end
    @(negedge clk_12_5875);
    fill_address = 12'h803;
    fill_data    = 8'h07;
    e.a = 12'h803; e.d = 8'h07; sb_fill.push_back(e);
    @(negedge clk_12_5875);
    fill_write_enable = 1'b0;
    @(negedge clk_12_5875);
    fill_phase = 0;
    fill_req   = 1'b0;
    done = 0;
    for (int k = 0; k < 6 && !done; k++) begin
      @(negedge clk_12_5875);
      if (fill_grant === 1'b0) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL fill_release got %b expected 0", fill_grant); end
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (write_count == wc0 + 8 && fifo_count === 5'd0) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL fill_resume got %0d writes expected 8", write_count - wc0); end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
  endtask

  task automatic test_reset_mid_drain();
    int wc0;
    bit done;
    in_vblank = 1'b0;
    for (int i = 0; i < 8; i++) cpu_write(12'h400 + 12'(i), 8'h40 + 8'(i), 1'b0);
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (fifo_count === 5'd5) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL rst_mid_setup got %0d expected 5", fifo_count); end
    rst_n = 1'b0;
    sb_fifo.delete();
    model_count = 0;
    #1;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("[TB] FAIL rst_mid_count got %0d expected 0", fifo_count); end
    checks++; if (vram_write_enable !== 1'b0 || vram_address !== 12'h000 || vram_data !== 8'h00) begin
      errors++; $display("[TB] FAIL rst_mid_vram got we=%b %h/%h expected 0 000/00", vram_write_enable, vram_address, vram_data);
    end
    checks++; if (fill_grant !== 1'b0 || cpu_full !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_flags got grant=%b full=%b ovf=%b expected 0 0 0", fill_grant, cpu_full, overflow);
    end
    @(negedge clk_12_5875);
    rst_n = 1'b1;
    wc0 = write_count;
    repeat (10) @(negedge clk_12_5875);
    checks++; if (write_count != wc0) begin errors++; $display("[TB] FAIL rst_stale_writes got %0d expected 0", write_count - wc0); end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
  endtask

  task automatic test_coalesce();
    int wc0;
    bit done;
`ifdef VRAM_WRITE_COALESCE_EN
    localparam int EXP_N = 1;
`else
    localparam int EXP_N = 2;
`endif
    in_vblank = 1'b0;
    cpu_write(12'h801, 8'h01, 1'b0);
    cpu_write(12'h801, 8'h0F, 1'b0);
    wc0 = write_count;
    @(negedge clk_12_5875);
    checks++; if (fifo_count !== 5'(EXP_N)) begin errors++; $display("[TB] FAIL coalesce_count got %0d expected %0d", fifo_count, EXP_N); end
    in_vblank = 1'b1;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk_12_5875);
      if (fifo_count === 5'd0) done = 1;
    end
    repeat (3) @(negedge clk_12_5875);
    checks++; if (!done || write_count != wc0 + EXP_N) begin
      errors++; $display("[TB] FAIL coalesce_writes got %0d expected %0d", write_count - wc0, EXP_N);
    end
    in_vblank = 1'b0;
    @(negedge clk_12_5875);
  endtask

  initial begin
    rst_n             = 1'b0;
    cpu_address       = '0;
    cpu_data          = '0;
    cpu_write_enable  = 1'b0;
    fill_req          = 1'b0;
    fill_address      = '0;
    fill_data         = '0;
    fill_write_enable = 1'b0;
    in_vblank         = 1'b0;
    clr_overflow      = 1'b0;
    $display("[TB] start");
    test_reset();
    test_vblank_drain();
    test_overflow();
    test_partial_drain();
    test_fill_preempt();
    test_reset_mid_drain();
    test_coalesce();
    repeat (5) @(negedge clk_12_5875);
    checks++; if (sb_fifo.size() != 0 || sb_fill.size() != 0) begin
      errors++; $display("[TB] FAIL missing_writes got %0d/%0d pending expected 0/0", sb_fifo.size(), sb_fill.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
